// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment display blocks: the hex font,
// the all-dark cathode pattern and the cathode bit positions.
package seg7_pkg;

  // Cathode bit positions; segments a..g occupy bits 0..6, decimal point bit 7.
  localparam int CAT_A  = 0;
  localparam int CAT_G  = 6;
  localparam int CAT_DP = 7;

  // All cathodes high: nothing lit.
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low hex font {dp,g..a} with the decimal point off.
  // Entry 0 is the rightmost element of the concatenation.
  localparam logic [15:0][7:0] FONT = {
    8'h8E, 8'h86, 8'hA1, 8'hC6,   // F E D C
    8'h83, 8'h88, 8'h90, 8'h80,   // B A 9 8
    8'hF8, 8'h82, 8'h92, 8'h99,   // 7 6 5 4
    8'hB0, 8'hA4, 8'hF9, 8'hC0    // 3 2 1 0
  };

endpackage

// File: rtl/seg7_decode.sv
// Hex nibble to active-low segment pattern {g..a}. Purely combinational so
// other display blocks can drop it in front of their own output registers.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  // Font lookup; the decimal point bit of the font entry is not used here.
  always_comb begin
    seg_n = FONT[nibble][CAT_G:CAT_A];
  end

endmodule

// File: rtl/seg7_scan_n.sv
// N-digit multiplexed seven-segment scanner with built-in prescaler,
// per-frame input snapshot, leading-zero blanking and PWM brightness.
// an/cat are registered together so a slot change never mixes the anode
// of one digit with the cathodes of another.
module seg7_scan_n
  import seg7_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int CLK_DIV  = 100000,
  parameter int BRIGHT_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic                  lz_blank,
  input  logic [BRIGHT_W-1:0]   brightness,
  output logic [DIGITS-1:0]     an,
  output logic [7:0]            cat,
  output logic                  frame_start
);

  localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int STEP  = CLK_DIV >> BRIGHT_W;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] snap_data_q, snap_data_d;
  logic [DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic [DIGITS-1:0]   snap_en_q, snap_en_d;
  logic                snap_lz_q, snap_lz_d;
  logic [BRIGHT_W-1:0] snap_bright_q, snap_bright_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [7:0]          cat_q, cat_d;
  logic                frame_start_q, frame_start_d;

  logic                take;
  logic [DIGITS-1:0]   blank;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_en;
  logic                cur_blank;
  logic [DIGITS-1:0]   cur_an;
  logic [31:0]         on_limit;
  logic                pwm_on;
  logic [6:0]          seg_n;

  // Prescaler and digit index: pre wraps every CLK_DIV cycles, idx steps on the wrap.
  always_comb begin
    pre_d = pre_q + 1'b1;
    idx_d = idx_q;
    if (pre_q == PRE_LAST) begin
      pre_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // Snapshot at the start of digit 0's slot; the _d values are also what the
  // output stage uses, so the first cycle of a frame already shows new data.
  always_comb begin
    take          = (pre_q == '0) && (idx_q == '0);
    snap_data_d   = snap_data_q;
    snap_dp_d     = snap_dp_q;
    snap_en_d     = snap_en_q;
    snap_lz_d     = snap_lz_q;
    snap_bright_d = snap_bright_q;
    frame_start_d = take;
    if (take) begin
      snap_data_d   = data;
      snap_dp_d     = dp;
      snap_en_d     = digit_en;
      snap_lz_d     = lz_blank;
      snap_bright_d = brightness;
    end
  end

  // Leading-zero blanking: walk down from the top digit while nibbles stay zero.
  always_comb begin
    logic tail_zero;
    tail_zero = 1'b1;
    blank     = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      tail_zero = tail_zero & (snap_data_d[4*k +: 4] == 4'd0);
      blank[k]  = snap_lz_d & tail_zero;
    end
  end

  // Select the current digit's nibble, dp, enable, blank flag and anode pattern.
  always_comb begin
    cur_nib   = 4'd0;
    cur_dp    = 1'b0;
    cur_en    = 1'b0;
    cur_blank = 1'b1;
    cur_an    = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_nib   = snap_data_d[4*k +: 4];
        cur_dp    = snap_dp_d[k];
        cur_en    = snap_en_d[k];
        cur_blank = blank[k];
        cur_an[k] = 1'b0;
      end
    end
  end

  seg7_decode u_decode (
    .nibble (cur_nib),
    .seg_n  (seg_n)
  );

  // Output stage: lit pattern inside the PWM on-window of a visible digit, dark otherwise.
  always_comb begin
    on_limit = (32'(snap_bright_d) + 32'd1) * 32'(STEP);
    pwm_on   = (32'(pre_q) < on_limit);
    an_d     = '1;
    cat_d    = SEG_BLANK;
    if (cur_en && !cur_blank && pwm_on) begin
      an_d               = cur_an;
      cat_d[CAT_G:CAT_A] = seg_n;
      cat_d[CAT_DP]      = ~cur_dp;
    end
  end

  // State and output registers; reset darkens the display and restarts at digit 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q         <= '0;
      idx_q         <= '0;
      snap_data_q   <= '0;
      snap_dp_q     <= '0;
      snap_en_q     <= '0;
      snap_lz_q     <= 1'b0;
      snap_bright_q <= '0;
      an_q          <= '1;
      cat_q         <= SEG_BLANK;
      frame_start_q <= 1'b0;
    end else begin
      pre_q         <= pre_d;
      idx_q         <= idx_d;
      snap_data_q   <= snap_data_d;
      snap_dp_q     <= snap_dp_d;
      snap_en_q     <= snap_en_d;
      snap_lz_q     <= snap_lz_d;
      snap_bright_q <= snap_bright_d;
      an_q          <= an_d;
      cat_q         <= cat_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign an          = an_q;
  assign cat         = cat_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_n.sv
// Directed bench for seg7_scan_n with DIGITS=4, CLK_DIV=16, BRIGHT_W=2.
// cyc is the scan cycle (counted from reset release) that the registered
// outputs currently reflect; slot positions are given as (frame, idx, pre).
module tb_seg7_scan_n;

  localparam int DIGITS   = 4;
  localparam int CLK_DIV  = 16;
  localparam int BRIGHT_W = 2;
  localparam int FRAME    = DIGITS * CLK_DIV;

  logic                clk = 1'b0;
  logic                rst;
  logic [4*DIGITS-1:0] data;
  logic [DIGITS-1:0]   dp;
  logic [DIGITS-1:0]   digit_en;
  logic                lz_blank;
  logic [BRIGHT_W-1:0] brightness;
  logic [DIGITS-1:0]   an;
  logic [7:0]          cat;
  logic                frame_start;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  seg7_scan_n #(
    .DIGITS   (DIGITS),
    .CLK_DIV  (CLK_DIV),
    .BRIGHT_W (BRIGHT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .data        (data),
    .dp          (dp),
    .digit_en    (digit_en),
    .lz_blank    (lz_blank),
    .brightness  (brightness),
    .an          (an),
    .cat         (cat),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto_slot(input int frame, input int idx, input int pre);
    int target;
    target = frame * FRAME + idx * CLK_DIV + pre;
    if (target < cyc) begin
      total++;
      bad++;
      $display("FAIL goto: at cycle %0d, required cycle %0d already passed", cyc, target);
    end
    while (cyc < target) tick();
  endtask

  task automatic chk_out(input string tag, input logic [3:0] an_exp, input logic [7:0] cat_exp);
    total++;
    assert (an === an_exp && cat === cat_exp) begin
      $display("ok   %s cyc=%0d an=%b cat=%h", tag, cyc, an, cat);
    end else begin
      bad++;
      $error("FAIL %s: cyc=%0d an=%b cat=%h, required an=%b cat=%h", tag, cyc, an, cat, an_exp, cat_exp);
    end
  endtask

  task automatic chk_fs(input string tag, input logic fs_exp);
    total++;
    assert (frame_start === fs_exp) begin
      $display("ok   %s cyc=%0d frame_start=%b", tag, cyc, frame_start);
    end else begin
      bad++;
      $error("FAIL %s: cyc=%0d frame_start=%b, required %b", tag, cyc, frame_start, fs_exp);
    end
  endtask

  initial begin
    rst        = 1'b1;
    data       = 16'hDEF0;
    dp         = 4'b0000;
    digit_en   = 4'b1111;
    lz_blank   = 1'b0;
    brightness = 2'd3;
    tick();
    tick();
    chk_out("reset", 4'b1111, 8'hFF);
    chk_fs("reset_fs", 1'b0);

    // 1: full brightness, one digit per 16-cycle slot
    rst = 1'b0;
    cyc = -1;
    goto_slot(0, 0, 0);  chk_out("t1_d0", 4'b1110, 8'hC0);  chk_fs("t1_fs_first", 1'b1);
    goto_slot(0, 0, 1);  chk_fs("t1_fs_low", 1'b0);
    goto_slot(0, 1, 0);  chk_out("t1_d1", 4'b1101, 8'h8E);
    goto_slot(0, 2, 0);  chk_out("t1_d2", 4'b1011, 8'h86);
    goto_slot(0, 3, 15); chk_out("t1_d3_end", 4'b0111, 8'hA1);
    goto_slot(1, 0, 0);  chk_out("t1_wrap", 4'b1110, 8'hC0);  chk_fs("t1_fs_64", 1'b1);

    // 2: brightness=1 -> lit for pre 0..7 only, from the next frame on
    brightness = 2'd1;
    goto_slot(1, 0, 8);  chk_out("t2_old_bright", 4'b1110, 8'hC0);
    goto_slot(2, 0, 0);  chk_out("t2_d0_on", 4'b1110, 8'hC0);  chk_fs("t2_fs", 1'b1);
    goto_slot(2, 0, 7);  chk_out("t2_d0_last_on", 4'b1110, 8'hC0);
    goto_slot(2, 0, 8);  chk_out("t2_d0_first_off", 4'b1111, 8'hFF);
    goto_slot(2, 1, 15); chk_out("t2_d1_off", 4'b1111, 8'hFF);
    goto_slot(2, 3, 7);  chk_out("t2_d3_on", 4'b0111, 8'hA1);

    // 3: leading-zero blanking
    data       = 16'h0050;
    lz_blank   = 1'b1;
    brightness = 2'd3;
    goto_slot(3, 0, 0);  chk_out("t3_d0", 4'b1110, 8'hC0);
    goto_slot(3, 1, 3);  chk_out("t3_d1", 4'b1101, 8'h92);
    goto_slot(3, 2, 0);  chk_out("t3_d2_blank", 4'b1111, 8'hFF);
    goto_slot(3, 3, 10); chk_out("t3_d3_blank", 4'b1111, 8'hFF);
    data = 16'h0000;
    goto_slot(4, 0, 0);  chk_out("t3_zero_d0", 4'b1110, 8'hC0);
    goto_slot(4, 1, 0);  chk_out("t3_zero_d1", 4'b1111, 8'hFF);

    // 4: per-digit enable and decimal point
    data     = 16'h1111;
    lz_blank = 1'b0;
    digit_en = 4'b1011;
    dp       = 4'b0010;
    goto_slot(5, 0, 0);  chk_out("t4_d0", 4'b1110, 8'hF9);
    goto_slot(5, 1, 0);  chk_out("t4_d1_dp", 4'b1101, 8'h79);
    goto_slot(5, 2, 0);  chk_out("t4_d2_off", 4'b1111, 8'hFF);
    goto_slot(5, 2, 15); chk_out("t4_d2_off_end", 4'b1111, 8'hFF);
    goto_slot(5, 3, 0);  chk_out("t4_d3", 4'b0111, 8'hF9);

    // 5: data change mid-frame must not tear the current frame
    data     = 16'h1234;
    digit_en = 4'b1111;
    dp       = 4'b0000;
    goto_slot(6, 0, 0);  chk_out("t5_d0", 4'b1110, 8'h99);
    goto_slot(6, 2, 2);
    data = 16'h5678;
    goto_slot(6, 2, 5);  chk_out("t5_d2_held", 4'b1011, 8'hA4);
    goto_slot(6, 3, 0);  chk_out("t5_d3_held", 4'b0111, 8'hF9);
    goto_slot(7, 0, 0);  chk_out("t5_new_d0", 4'b1110, 8'h80);  chk_fs("t5_fs", 1'b1);
    goto_slot(7, 2, 0);  chk_out("t5_new_d2", 4'b1011, 8'h82);

    // 6: one-cycle reset in the middle of digit 2's slot
    goto_slot(7, 2, 6);
    rst  = 1'b1;
    data = 16'h4321;
    tick();
    chk_out("t6_reset_dark", 4'b1111, 8'hFF);
    chk_fs("t6_reset_fs", 1'b0);
    rst = 1'b0;
    cyc = -1;
    goto_slot(0, 0, 0);  chk_out("t6_restart_d0", 4'b1110, 8'hF9);  chk_fs("t6_restart_fs", 1'b1);
    goto_slot(0, 1, 0);  chk_out("t6_restart_d1", 4'b1101, 8'hA4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
